// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to single APB3 initiator transfers, one outstanding at a time.
// Returns read data / slave error / timeout through a valid/ready response stream.
module apb_master_bridge #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              prst,
    // command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB initiator
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam bit          TO_EN    = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic              to_hit;

    // Last permitted wait cycle: abort unless pready arrives now.
    assign to_hit = TO_EN && (cnt_q == CNT_W'(CNT_LAST));

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        cnt_q    <= '0;
                        psel_q   <= 1'b1;
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= S_RESP;
                    end else if (to_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;

    // APB protocol invariants of the initiator side.
    a_enable_needs_sel: assert property (@(posedge pclk) disable iff (prst) penable_q |-> psel_q);
    a_addr_stable:      assert property (@(posedge pclk) disable iff (prst)
                                         (state_q == S_ACCESS) |-> $stable(paddr_q));

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge: behavioural APB responder plus a
// transaction-level model of the expected response, latency and APB phase counts.
module tb_apb_master_bridge;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TO_CYC = 16;

    logic              pclk;
    logic              prst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    apb_master_bridge #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc;
    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] seed_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Responder: inserts wait_n wait states, then completes with err_flag as pslverr.
    int                wait_n;
    bit                err_flag;
    int                acc_seen;
    bit                rmem_init;
    logic [DATA_W-1:0] rmem [16];

    always @(negedge pclk) begin
        if (!rmem_init) begin
            for (int i = 0; i < 16; i++) rmem[i] = seed_word(i);
            rmem_init = 1'b1;
        end
        if (psel && penable) begin
            pready   = (acc_seen >= wait_n);
            acc_seen = acc_seen + 1;
            if (pready) begin
                pslverr = err_flag;
                prdata  = pwrite ? DATA_W'($urandom) : rmem[paddr];
                if (pwrite && !err_flag) rmem[paddr] = pwdata;
            end else begin
                pslverr = 1'($urandom);
                prdata  = DATA_W'($urandom);
            end
        end else begin
            acc_seen = 0;
            pready   = 1'($urandom);
            pslverr  = 1'($urandom);
            prdata   = DATA_W'($urandom);
        end
    end

    // Transaction-level reference model.
    typedef struct {
        logic [DATA_W-1:0] rdata;
        bit                err;
        bit                to;
        int                n_acc;
        int                acc_cyc;
    } exp_t;

    logic [DATA_W-1:0] mmem [16];
    exp_t              exp_q[$];

    function automatic exp_t predict(input bit wr, input logic [ADDR_W-1:0] a, input int wn,
                                     input bit er);
        exp_t e;
        e.to      = (TO_CYC > 0) && (wn >= int'(TO_CYC));
        e.n_acc   = e.to ? int'(TO_CYC) : wn + 1;
        e.err     = e.to ? 1'b1 : er;
        e.rdata   = (wr || e.to) ? '0 : mmem[a];
        e.acc_cyc = 0;
        if (wr && !e.to && !er) mmem[a] = cmd_wdata;
        return e;
    endfunction

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = DATA_W'($urandom);
    endtask

    // One transfer from an IDLE negedge back to the IDLE negedge after the handshake.
    task automatic do_xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                           input int wn, input bit er, input int hold);
        exp_t e;
        int   n;
        int   n_setup;
        int   n_acc;
        check_eq("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        wait_n    = wn;
        err_flag  = er;
        rsp_ready = 1'b0;
        e = predict(wr, a, wn, er);
        @(negedge pclk);
        n       = 1;
        n_setup = 0;
        n_acc   = 0;
        while (!rsp_valid && n < 200) begin
            if (psel) begin
                if (penable) n_acc++;
                else n_setup++;
                check_eq("paddr_held", 64'(paddr), 64'(a));
                check_eq("pwrite_held", 64'(pwrite), 64'(wr));
                if (wr) check_eq("pwdata_held", 64'(pwdata), 64'(wd));
            end
            check_eq("busy_cmd_ready", 64'(cmd_ready), 64'(0));
            scramble_cmd();
            @(negedge pclk);
            n++;
        end
        check_eq("rsp_latency", 64'(n), 64'(e.n_acc + 2));
        check_eq("setup_cycles", 64'(n_setup), 64'(1));
        check_eq("access_cycles", 64'(n_acc), 64'(e.n_acc));
        for (int h = 0; h <= hold; h++) begin
            check_eq("rsp_valid", 64'(rsp_valid), 64'(1));
            check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
            check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            check_eq("resp_psel", 64'({psel, penable}), 64'(0));
            check_eq("resp_cmd_ready", 64'(cmd_ready), 64'(0));
            if (h == hold) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                scramble_cmd();
            end
            @(negedge pclk);
        end
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("post_cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    bit                r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wd;
    int                r_wn;
    bit                r_er;
    int                r_hold;
    exp_t              e_drv;
    exp_t              e_col;
    int                last_acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        wait_n    = 0;
        err_flag  = 1'b0;
        for (int i = 0; i < 16; i++) mmem[i] = seed_word(i);
        prst = 1'b1;
        repeat (3) @(negedge pclk);

        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("rst_apb", 64'({psel, penable, pwrite}), 64'(0));
        check_eq("rst_paddr", 64'(paddr), 64'(0));
        check_eq("rst_pwdata", 64'(pwdata), 64'(0));
        check_eq("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        prst = 1'b0;
        @(negedge pclk);

        // Directed: minimum-latency write, wait-state read, slave error with backpressure.
        do_xfer(1'b1, 4'h4, 32'hDEAD_BEEF, 0, 1'b0, 0);
        do_xfer(1'b1, 4'h0, 32'h1234_5678, 0, 1'b0, 1);
        do_xfer(1'b0, 4'h0, 32'h0, 3, 1'b0, 0);
        do_xfer(1'b0, 4'h8, 32'h0, 0, 1'b1, 5);
        do_xfer(1'b0, 4'h4, 32'h0, 1, 1'b0, 0);

        // Timeout boundary: stuck responder, then pready on the very last allowed cycle.
        do_xfer(1'b0, 4'h2, 32'h0, 40, 1'b0, 0);
        do_xfer(1'b0, 4'h2, 32'h0, int'(TO_CYC) - 1, 1'b0, 0);
        do_xfer(1'b1, 4'h3, 32'hA5A5_5A5A, 30, 1'b0, 2);
        do_xfer(1'b0, 4'h3, 32'h0, 0, 1'b0, 0);

        // Synchronous reset during an ACCESS wait state.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'h6;
        wait_n    = 50;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        check_eq("pre_rst_penable", 64'(penable), 64'(1));
        prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        check_eq("midrst_apb", 64'({psel, penable}), 64'(0));
        check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("midrst_rsp_flags", 64'({rsp_err, rsp_timeout}), 64'(0));
        check_eq("midrst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        do_xfer(1'b1, 4'h6, 32'hCAFE_F00D, 0, 1'b0, 0);
        do_xfer(1'b0, 4'h6, 32'h0, 2, 1'b0, 0);

        // Back-to-back with cmd_valid and rsp_ready held high.
        wait_n    = 0;
        err_flag  = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        last_acc  = 0;
        fork
            begin
                int k;
                for (int i = 0; i < 8; i++) begin
                    cmd_write = 1'($urandom);
                    cmd_addr  = ADDR_W'($urandom);
                    cmd_wdata = DATA_W'($urandom);
                    k = 0;
                    while (!cmd_ready && k < 20) begin
                        @(negedge pclk);
                        k++;
                    end
                    e_drv = predict(cmd_write, cmd_addr, 0, 1'b0);
                    e_drv.acc_cyc = cyc;
                    if (i > 0) check_eq("b2b_spacing", 64'(cyc - last_acc), 64'(4));
                    last_acc = cyc;
                    exp_q.push_back(e_drv);
                    @(negedge pclk);
                end
                cmd_valid = 1'b0;
            end
            begin
                int k;
                for (int i = 0; i < 8; i++) begin
                    k = 0;
                    while (!rsp_valid && k < 50) begin
                        @(negedge pclk);
                        k++;
                    end
                    check_eq("b2b_rsp_seen", 64'(rsp_valid), 64'(1));
                    check_eq("b2b_pending", 64'(exp_q.size()), 64'(1));
                    if (exp_q.size() > 0) begin
                        e_col = exp_q.pop_front();
                        check_eq("b2b_latency", 64'(cyc - e_col.acc_cyc), 64'(3));
                        check_eq("b2b_rdata", 64'(rsp_rdata), 64'(e_col.rdata));
                        check_eq("b2b_err", 64'({rsp_err, rsp_timeout}), 64'(0));
                    end
                    @(negedge pclk);
                end
            end
        join
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge pclk);

        // Randomized mix: wait states, occasional timeouts, slave errors, backpressure.
        for (int i = 0; i < 30; i++) begin
            r_wr   = 1'($urandom);
            r_addr = ADDR_W'($urandom);
            r_wd   = DATA_W'($urandom);
            r_wn   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20))
                                                 : int'($urandom_range(0, 4));
            r_er   = ($urandom_range(0, 3) == 0);
            r_hold = int'($urandom_range(0, 3));
            do_xfer(r_wr, r_addr, r_wd, r_wn, r_er, r_hold);
        end

        // Read every address back to confirm the write history seen by the responder.
        for (int i = 0; i < 16; i++) do_xfer(1'b0, ADDR_W'(i), 32'h0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
